// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch squash stage: FSM state encoding,
// the default bubble encoding and the legal range of the post-redirect
// squash length.
package fetch_pkg;

   // IDLE: core not running; FETCH: delivering or waiting on the I-cache;
   // SQUASH: counting out the extra bubbles after a redirect.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      SQUASH = 2'd2
   } fetch_state_t;

   // Encoding injected into the pipe as a bubble.
   localparam logic [15:0] NOP_INSTR = 16'h0000;

   // Extra bubble cycles after the redirect cycle.
   localparam int SQUASH_CYCLES_MIN = 1;
   localparam int SQUASH_CYCLES_MAX = 15;

   // Pull an out-of-range squash length back into the legal window so the
   // counter is never built with a zero or oversized load value.
   function automatic int clamp_squash_cycles(input int n);
      if (n < SQUASH_CYCLES_MIN) return SQUASH_CYCLES_MIN;
      if (n > SQUASH_CYCLES_MAX) return SQUASH_CYCLES_MAX;
      return n;
   endfunction

endpackage

// File: rtl/fetch_squash_unit_squash_ctr.sv
// Loadable down-counter that times the bubbles following a redirect.
// clear_i has priority over load_i, which has priority over en_i. term_o
// flags the last squash cycle (count == 1) so the owner can leave SQUASH on
// that edge. The count stops at zero if enabled past the terminal value.
module squash_ctr
   import fetch_pkg::*;
#(
   parameter int SQUASH_CYCLES = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic load_i,
   input  logic en_i,
   output logic term_o
);

   localparam int LOAD_N = clamp_squash_cycles(SQUASH_CYCLES);
   localparam int CW     = $clog2(LOAD_N + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: clear beats load beats decrement.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = CW'(LOAD_N);
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // Count register, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign term_o = (cnt_q == CW'(1));

endmodule

// File: rtl/fetch_squash_unit.sv
// Registered instruction-delivery stage between the I-cache and IF/ID.
// Injects NOP bubbles while the core is stopped, on I-cache miss, and for
// 1 + SQUASH_CYCLES non-stalled cycles after a jump or mispredict flush.
// Holds its output while stall is high.
//
// Flow control: there is no valid/ready handshake. valid_o only marks
// instr_o as a real instruction. While stall is high the upstream PC logic
// must keep presenting the same instr_i; nothing is captured during stall,
// except that a flush (jump | miss) or run = 0 still takes effect.
//
// Optional feature: define FETCH_BUBBLE_CNT_EN to add bubble_cnt_o, a
// saturating count of every bubble loaded, cleared only by rst.
module fetch_squash_unit
   import fetch_pkg::*;
#(
   parameter int               WIDTH         = 16,
   parameter logic [WIDTH-1:0] NOP           = WIDTH'(NOP_INSTR),
   parameter int               SQUASH_CYCLES = 1
`ifdef FETCH_BUBBLE_CNT_EN
   ,
   parameter int               CNT_W         = 16
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             i_hit,
   input  logic             jump,
   input  logic             miss,
   input  logic             stall,
   input  logic [WIDTH-1:0] instr_i,
   output logic [WIDTH-1:0] instr_o,
   output logic             valid_o,
   output logic             squashing_o,
   output fetch_state_t     state_o
`ifdef FETCH_BUBBLE_CNT_EN
   ,
   output logic [CNT_W-1:0] bubble_cnt_o
`endif
);

   localparam int SQ_N = clamp_squash_cycles(SQUASH_CYCLES);

   fetch_state_t     state_q;
   logic [WIDTH-1:0] instr_q;
   logic             valid_q;

   logic flush;
   logic in_squash;
   logic sq_clear;
   logic sq_load;
   logic sq_dec;
   logic sq_term;

   assign flush     = jump | miss;
   assign in_squash = (state_q == SQUASH);

   // Counter control mirrors the FSM priority: stop, then redirect, then
   // stall (freeze), then count down while squashing.
   assign sq_clear = ~run;
   assign sq_load  = run & flush;
   assign sq_dec   = run & ~flush & ~stall & in_squash;

   squash_ctr #(
      .SQUASH_CYCLES (SQ_N)
   ) u_squash_ctr (
      .clk     (clk),
      .rst     (rst),
      .clear_i (sq_clear),
      .load_i  (sq_load),
      .en_i    (sq_dec),
      .term_o  (sq_term)
   );

   // Delivery FSM with registered instruction/valid outputs; first match wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         instr_q <= NOP;
         valid_q <= 1'b0;
      end else if (!run) begin
         state_q <= IDLE;
         instr_q <= NOP;
         valid_q <= 1'b0;
      end else if (flush) begin
         // A redirect wins over stall and restarts any squash in progress.
         state_q <= SQUASH;
         instr_q <= NOP;
         valid_q <= 1'b0;
      end else if (stall) begin
         state_q <= state_q;
         instr_q <= instr_q;
         valid_q <= valid_q;
      end else if (in_squash) begin
         instr_q <= NOP;
         valid_q <= 1'b0;
         if (sq_term) begin
            state_q <= FETCH;
         end
      end else if (!i_hit) begin
         state_q <= FETCH;
         instr_q <= NOP;
         valid_q <= 1'b0;
      end else begin
         state_q <= FETCH;
         instr_q <= instr_i;
         valid_q <= 1'b1;
      end
   end

   assign instr_o     = instr_q;
   assign valid_o     = valid_q;
   assign squashing_o = in_squash;
   assign state_o     = state_q;

`ifdef FETCH_BUBBLE_CNT_EN
   logic [CNT_W-1:0] bub_cnt_q;
   logic             bub_inc;

   // A bubble is loaded whenever the FSM takes a branch that writes valid 0
   // while running: a flush, or an unstalled squash / I-cache miss cycle.
   assign bub_inc = run & (flush | (~stall & (in_squash | ~i_hit)));

   // Saturating bubble counter; only rst clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bub_cnt_q <= '0;
      end else if (bub_inc && (bub_cnt_q != '1)) begin
         bub_cnt_q <= bub_cnt_q + CNT_W'(1);
      end
   end

   assign bubble_cnt_o = bub_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_squash_unit.sv
// Directed bench for fetch_squash_unit. dut3 (SQUASH_CYCLES = 3) carries the
// vector table; dut2 (SQUASH_CYCLES = 2) shares the same stimulus and is
// checked in the squash-restart and mid-squash reset sequences. With
// FETCH_BUBBLE_CNT_EN defined, dut3 is built with CNT_W = 2 to exercise
// counter saturation.
module tb_fetch_squash_unit;
   import fetch_pkg::*;

   localparam int W = 16;
   localparam logic [W-1:0] NOP_V = 16'h0000;

   // Clock and reset
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic         run = 1'b0, i_hit = 1'b0, jump = 1'b0, miss = 1'b0, stall = 1'b0;
   logic [W-1:0] instr_i = '0;

   logic [W-1:0] instr3_o, instr2_o;
   logic         valid3_o, valid2_o, sq3_o, sq2_o;
   fetch_state_t st3_o, st2_o;
`ifdef FETCH_BUBBLE_CNT_EN
   logic [1:0]   bcnt3_o;
   logic [15:0]  bcnt2_o;
`endif

   int checks = 0;
   int errors = 0;

   fetch_squash_unit #(
      .WIDTH (W), .NOP (NOP_V), .SQUASH_CYCLES (3)
`ifdef FETCH_BUBBLE_CNT_EN
      , .CNT_W (2)
`endif
   ) dut3 (
      .clk (clk), .rst (rst), .run (run), .i_hit (i_hit), .jump (jump),
      .miss (miss), .stall (stall), .instr_i (instr_i), .instr_o (instr3_o),
      .valid_o (valid3_o), .squashing_o (sq3_o), .state_o (st3_o)
`ifdef FETCH_BUBBLE_CNT_EN
      , .bubble_cnt_o (bcnt3_o)
`endif
   );

   fetch_squash_unit #(
      .WIDTH (W), .NOP (NOP_V), .SQUASH_CYCLES (2)
`ifdef FETCH_BUBBLE_CNT_EN
      , .CNT_W (16)
`endif
   ) dut2 (
      .clk (clk), .rst (rst), .run (run), .i_hit (i_hit), .jump (jump),
      .miss (miss), .stall (stall), .instr_i (instr_i), .instr_o (instr2_o),
      .valid_o (valid2_o), .squashing_o (sq2_o), .state_o (st2_o)
`ifdef FETCH_BUBBLE_CNT_EN
      , .bubble_cnt_o (bcnt2_o)
`endif
   );

   // Vector record: inputs for one edge and dut3 outputs expected after it.
   typedef struct packed {
      logic         run;
      logic         hit;
      logic         jmp;
      logic         mis;
      logic         stl;
      logic [W-1:0] instr;
      logic [W-1:0] exp_instr;
      logic         exp_valid;
      logic         exp_sq;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic h, input logic j, input logic m,
                      input logic s, input logic [W-1:0] in, input logic [W-1:0] ex,
                      input logic ev, input logic es);
      vec_t v;
      v.run = r; v.hit = h; v.jmp = j; v.mis = m; v.stl = s;
      v.instr = in; v.exp_instr = ex; v.exp_valid = ev; v.exp_sq = es;
      vecs.push_back(v);
   endtask

   // Scoreboard compare
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Driver: advance one edge and settle past it before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic h, input logic j, input logic m,
                        input logic s, input logic [W-1:0] in);
      run = r; i_hit = h; jump = j; miss = m; stall = s; instr_i = in;
   endtask

   initial begin
      // Jump with stream A..E: four bubbles, squashing high three cycles, then E.
      add(1,1,1,0,0, 16'h0A0A, NOP_V,    0, 1);
      add(1,1,0,0,0, 16'h0B0B, NOP_V,    0, 1);
      add(1,1,0,0,0, 16'h0C0C, NOP_V,    0, 1);
      add(1,1,0,0,0, 16'h0D0D, NOP_V,    0, 0);
      add(1,1,0,0,0, 16'h0E0E, 16'h0E0E, 1, 0);
      // I-cache miss twice, then the same word delivered.
      add(1,0,0,0,0, 16'hBEEF, NOP_V,    0, 0);
      add(1,0,0,0,0, 16'hBEEF, NOP_V,    0, 0);
      add(1,1,0,0,0, 16'hBEEF, 16'hBEEF, 1, 0);
      // Stall in FETCH holds, then resumes.
      add(1,1,0,0,1, 16'h1111, 16'hBEEF, 1, 0);
      add(1,1,0,0,0, 16'h1111, 16'h1111, 1, 0);
      // run low beats jump and stall; return goes straight to delivery.
      add(0,1,1,0,1, 16'h2222, NOP_V,    0, 0);
      add(1,1,0,0,0, 16'h2222, 16'h2222, 1, 0);
      // Mispredict, two stalled cycles at count 2, squash resumes.
      add(1,1,0,1,0, 16'h3333, NOP_V,    0, 1);
      add(1,1,0,0,0, 16'h3333, NOP_V,    0, 1);
      add(1,1,0,0,1, 16'h3333, NOP_V,    0, 1);
      add(1,1,0,0,1, 16'h3333, NOP_V,    0, 1);
      add(1,1,0,0,0, 16'h3333, NOP_V,    0, 1);
      add(1,1,0,0,0, 16'h3333, NOP_V,    0, 0);
      add(1,1,0,0,0, 16'h3333, 16'h3333, 1, 0);
      // Miss asserted during stall flushes at once and reloads.
      add(1,1,0,1,1, 16'h4444, NOP_V,    0, 1);
      add(1,1,0,0,0, 16'h4444, NOP_V,    0, 1);
      add(1,1,0,0,0, 16'h4444, NOP_V,    0, 1);
      add(1,1,0,0,0, 16'h4444, NOP_V,    0, 0);
      add(1,1,0,0,0, 16'h4444, 16'h4444, 1, 0);
      // run dropped mid-squash abandons it.
      add(1,1,1,0,0, 16'h5555, NOP_V,    0, 1);
      add(0,1,0,0,0, 16'h5555, NOP_V,    0, 0);
      add(1,1,0,0,0, 16'h5555, 16'h5555, 1, 0);

      // Asynchronous reset mid-cycle with a hit presented.
      drive(1, 1, 0, 0, 0, 16'h1234);
      step();
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_instr", 32'(instr3_o), 32'(NOP_V));
      check("rst_async_valid", 32'(valid3_o), 32'(0));
      check("rst_async_sq",    32'(sq3_o),    32'(0));
      step();
      check("rst_held_valid",  32'(valid3_o), 32'(0));
      check("rst_held_state",  32'(st3_o),    32'(IDLE));
      @(negedge clk);
      rst = 1'b0;
      step();
      check("rst_first_instr", 32'(instr3_o), 32'h1234);
      check("rst_first_valid", 32'(valid3_o), 32'(1));

      // Vector table
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].run, vecs[i].hit, vecs[i].jmp, vecs[i].mis, vecs[i].stl, vecs[i].instr);
         step();
         check($sformatf("v%0d_instr", i), 32'(instr3_o), 32'(vecs[i].exp_instr));
         check($sformatf("v%0d_valid", i), 32'(valid3_o), 32'(vecs[i].exp_valid));
         check($sformatf("v%0d_squash", i), 32'(sq3_o), 32'(vecs[i].exp_sq));
      end

      // Squash restart on dut2: second jump lands on bubble 2.
      begin
         logic jpat [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
         logic vexp [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
         logic sexp [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
         int   bubbles = 0;
         for (int k = 0; k < 5; k++) begin
            drive(1, 1, jpat[k], 0, 0, 16'h7777);
            step();
            if (!valid2_o) bubbles++;
            check($sformatf("restart%0d_valid", k), 32'(valid2_o), 32'(vexp[k]));
            check($sformatf("restart%0d_squash", k), 32'(sq2_o), 32'(sexp[k]));
         end
         check("restart_bubbles", 32'(bubbles), 32'(4));
         check("restart_instr",   32'(instr2_o), 32'h7777);
      end

      // Reset asserted in the middle of a squash on dut2.
      drive(1, 1, 1, 0, 0, 16'h6666);
      step();
      jump = 1'b0;
      check("midsq_pre_squash", 32'(sq2_o), 32'(1));
      #2;
      rst = 1'b1;
      #1;
      check("midsq_rst_squash", 32'(sq2_o),    32'(0));
      check("midsq_rst_state",  32'(st2_o),    32'(IDLE));
      check("midsq_rst_instr",  32'(instr2_o), 32'(NOP_V));
      @(negedge clk);
      rst = 1'b0;
      step();
      check("midsq_after_instr", 32'(instr2_o), 32'h6666);
      check("midsq_after_valid", 32'(valid2_o), 32'(1));

`ifdef FETCH_BUBBLE_CNT_EN
      // Bubble counter: run-low cycles ignored, saturates at 3 with CNT_W = 2.
      drive(0, 0, 0, 0, 0, 16'h0000);
      #2;
      rst = 1'b1;
      #1;
      check("bcnt_rst", 32'(bcnt3_o), 32'(0));
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("bcnt_idle%0d", k), 32'(bcnt3_o), 32'(0));
      end
      drive(1, 0, 0, 0, 0, 16'h0000);
      for (int k = 1; k <= 5; k++) begin
         step();
         check($sformatf("bcnt_run%0d", k), 32'(bcnt3_o), 32'((k > 3) ? 3 : k));
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
